// File: rtl/id_stage.sv
// id_stage -- RV32I instruction decode stage and ID/EX pipeline register.
// Decodes the IF/ID instruction, reads the register file in the same cycle,
// resolves jumps and branches in ID and reports load-use hazards.
// Build option: define ID_FWD_EN to forward the EX result of the instruction
// held in ID/EX into the ID operands; without it any RAW dependence on the
// ID/EX instruction is reported as a hazard instead.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_insn,
  input  logic        if_en,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  gpr_rs1_addr,
  output logic [4:0]  gpr_rs2_addr,
  input  logic [31:0] gpr_rs1_data,
  input  logic [31:0] gpr_rs2_data,
  input  logic [31:0] ex_fwd_data,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic        ld_hazard,
  output logic [31:0] id_pc,
  output logic        id_en,
  output logic [3:0]  id_alu_op,
  output logic [31:0] id_alu_in_0,
  output logic [31:0] id_alu_in_1,
  output logic [1:0]  id_mem_op,
  output logic [31:0] id_mem_wr_data,
  output logic [4:0]  id_dst_addr,
  output logic        id_gpr_we,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] MEM_NOP = 2'd0;
  localparam logic [1:0] MEM_LW  = 2'd1;
  localparam logic [1:0] MEM_SW  = 2'd2;

  // Contents of the ID/EX register; an all-zero value is a bubble.
  typedef struct packed {
    logic [31:0] pc;
    logic        en;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_0;
    logic [31:0] alu_in_1;
    logic [1:0]  mem_op;
    logic [31:0] mem_wr_data;
    logic [4:0]  dst_addr;
    logic        gpr_we;
    logic        illegal;
  } idex_t;

  idex_t       r_idex;
  idex_t       w_dec;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic        w_legal;
  logic        w_writes;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_br;
  logic        w_br_cond;
  logic        w_raw;

  // ALU operation selected by funct3; alt picks SUB/SRA over ADD/SRL.
  function automatic logic [3:0] f_alu_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign w_opcode = if_insn[6:0];
  assign w_rd     = if_insn[11:7];
  assign w_funct3 = if_insn[14:12];
  assign w_rs1    = if_insn[19:15];
  assign w_rs2    = if_insn[24:20];
  assign w_funct7 = if_insn[31:25];

  assign w_imm_i = {{20{if_insn[31]}}, if_insn[31:20]};
  assign w_imm_s = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
  assign w_imm_b = {{19{if_insn[31]}}, if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:8], 1'b0};
  assign w_imm_u = {if_insn[31:12], 12'd0};
  assign w_imm_j = {{11{if_insn[31]}}, if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:21], 1'b0};

  assign gpr_rs1_addr = w_rs1;
  assign gpr_rs2_addr = w_rs2;

  // A source matching the destination of the ID/EX instruction is a RAW dependence.
  assign w_raw = (w_use_rs1 && (w_rs1 == id_dst_addr)) ||
                 (w_use_rs2 && (w_rs2 == id_dst_addr));

`ifdef ID_FWD_EN
  logic w_fwd_ok;

  // Only a non-load result is available from EX this cycle; loads still stall.
  assign w_fwd_ok  = id_en && id_gpr_we && (id_dst_addr != 5'd0) && (id_mem_op != MEM_LW);
  assign w_rs1_val = (w_fwd_ok && (w_rs1 == id_dst_addr)) ? ex_fwd_data : gpr_rs1_data;
  assign w_rs2_val = (w_fwd_ok && (w_rs2 == id_dst_addr)) ? ex_fwd_data : gpr_rs2_data;
  assign ld_hazard = if_en && id_en && (id_mem_op == MEM_LW) && (id_dst_addr != 5'd0) && w_raw;
`else
  logic w_unused_fwd;

  // No bypass path: every dependence on the ID/EX writer has to wait.
  assign w_unused_fwd = ^ex_fwd_data;
  assign w_rs1_val    = gpr_rs1_data;
  assign w_rs2_val    = gpr_rs2_data;
  assign ld_hazard    = if_en && id_en && id_gpr_we && (id_dst_addr != 5'd0) && w_raw;
`endif

  // Decode the IF/ID instruction into the value the ID/EX register would load.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_dec          = '0;
    w_dec.pc       = if_pc;
    w_dec.en       = 1'b1;
    w_dec.alu_op   = ALU_ADD;
    w_dec.mem_op   = MEM_NOP;
    w_legal        = 1'b0;
    w_writes       = 1'b0;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_is_jal       = 1'b0;
    w_is_jalr      = 1'b0;
    w_is_br        = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        if ((w_funct7 == 7'h00) ||
            ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)))) begin
          w_legal        = 1'b1;
          w_writes       = 1'b1;
          w_use_rs1      = 1'b1;
          w_use_rs2      = 1'b1;
          w_dec.alu_op   = f_alu_op(w_funct3, w_funct7[5]);
          w_dec.alu_in_0 = w_rs1_val;
          w_dec.alu_in_1 = w_rs2_val;
        end
      end
      OPC_OP_IMM: begin
        if ((w_funct3 == 3'd1) ? (w_funct7 == 7'h00) :
            (w_funct3 == 3'd5) ? ((w_funct7 == 7'h00) || (w_funct7 == 7'h20)) : 1'b1) begin
          w_legal        = 1'b1;
          w_writes       = 1'b1;
          w_use_rs1      = 1'b1;
          w_dec.alu_op   = f_alu_op(w_funct3, (w_funct3 == 3'd5) && w_funct7[5]);
          w_dec.alu_in_0 = w_rs1_val;
          w_dec.alu_in_1 = w_imm_i;
        end
      end
      OPC_LUI: begin
        w_legal        = 1'b1;
        w_writes       = 1'b1;
        w_dec.alu_in_1 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal        = 1'b1;
        w_writes       = 1'b1;
        w_dec.alu_in_0 = if_pc;
        w_dec.alu_in_1 = w_imm_u;
      end
      OPC_JAL: begin
        w_legal        = 1'b1;
        w_writes       = 1'b1;
        w_is_jal       = 1'b1;
        w_dec.alu_in_0 = if_pc;
        w_dec.alu_in_1 = 32'd4;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'd0) begin
          w_legal        = 1'b1;
          w_writes       = 1'b1;
          w_use_rs1      = 1'b1;
          w_is_jalr      = 1'b1;
          w_dec.alu_in_0 = if_pc;
          w_dec.alu_in_1 = 32'd4;
        end
      end
      OPC_BRANCH: begin
        // Branches resolve here; only the valid mark travels down the pipe.
        if ((w_funct3 != 3'd2) && (w_funct3 != 3'd3)) begin
          w_legal   = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_is_br   = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (w_funct3 == 3'd2) begin
          w_legal        = 1'b1;
          w_writes       = 1'b1;
          w_use_rs1      = 1'b1;
          w_dec.mem_op   = MEM_LW;
          w_dec.alu_in_0 = w_rs1_val;
          w_dec.alu_in_1 = w_imm_i;
        end
      end
      OPC_STORE: begin
        if (w_funct3 == 3'd2) begin
          w_legal           = 1'b1;
          w_use_rs1         = 1'b1;
          w_use_rs2         = 1'b1;
          w_dec.mem_op      = MEM_SW;
          w_dec.alu_in_0    = w_rs1_val;
          w_dec.alu_in_1    = w_imm_s;
          w_dec.mem_wr_data = w_rs2_val;
        end
      end
      default: ;
    endcase
    // Writes to x0 are dropped, and the destination is only meaningful with a write.
    w_dec.gpr_we   = w_legal && w_writes && (w_rd != 5'd0);
    w_dec.dst_addr = w_dec.gpr_we ? w_rd : 5'd0;
    w_dec.illegal  = !w_legal;
  end

  // Evaluate the branch condition on the resolved (possibly forwarded) operands.
  always_comb begin
    case (w_funct3)
      3'd0:    w_br_cond = (w_rs1_val == w_rs2_val);
      3'd1:    w_br_cond = (w_rs1_val != w_rs2_val);
      3'd4:    w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'd5:    w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'd6:    w_br_cond = (w_rs1_val <  w_rs2_val);
      3'd7:    w_br_cond = (w_rs1_val >= w_rs2_val);
      default: w_br_cond = 1'b0;
    endcase
  end

  assign br_addr  = w_is_jalr ? ((w_rs1_val + w_imm_i) & ~32'd1)
                              : (if_pc + (w_is_jal ? w_imm_j : w_imm_b));
  assign br_taken = if_en && !ld_hazard && !flush &&
                    (w_is_jal || w_is_jalr || (w_is_br && w_br_cond));

  // ID/EX register: flush beats stall, stall beats a hazard bubble.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (!reset) begin
      r_idex <= '0;
    end else if (flush) begin
      r_idex <= '0;
    end else if (stall) begin
      r_idex <= r_idex;
    end else if (ld_hazard || !if_en) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_dec;
    end
  end

  assign id_pc          = r_idex.pc;
  assign id_en          = r_idex.en;
  assign id_alu_op      = r_idex.alu_op;
  assign id_alu_in_0    = r_idex.alu_in_0;
  assign id_alu_in_1    = r_idex.alu_in_1;
  assign id_mem_op      = r_idex.mem_op;
  assign id_mem_wr_data = r_idex.mem_wr_data;
  assign id_dst_addr    = r_idex.dst_addr;
  assign id_gpr_we      = r_idex.gpr_we;
  assign id_illegal     = r_idex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage -- directed and randomized checks of id_stage against a
// behavioural model that works from instruction descriptors (mnemonic,
// registers, immediate value) rather than from encoded bit fields.
module tb_id_stage;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum int {K_OP, K_OPI, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LW, K_SW, K_ILL} kind_e;

  typedef struct {
    kind_e       kind;
    int          op;     // ALU code for OP/OPI, condition index for branches
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;    // the immediate value the instruction means
    logic [31:0] raw;    // encoding for K_ILL
  } ins_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        en;
    logic [3:0]  alu_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [1:0]  mem;
    logic [31:0] wr;
    logic [4:0]  dst;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_insn;
  logic        if_en, stall, flush;
  logic [4:0]  gpr_rs1_addr, gpr_rs2_addr;
  logic [31:0] gpr_rs1_data, gpr_rs2_data, ex_fwd_data;
  logic        br_taken, ld_hazard;
  logic [31:0] br_addr, id_pc, id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic        id_en, id_gpr_we, id_illegal;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_mem_op;
  logic [4:0]  id_dst_addr;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] rf [32];
  logic [31:0] fwd_val;
  exp_t        cur, nxt;

  // funct3/funct7 per ALU code: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU
  int f3_tab [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
  int f7_tab [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  // funct3 per branch condition: BEQ BNE BLT BGE BLTU BGEU
  int bf3_tab [6] = '{0, 1, 4, 5, 6, 7};

  always #5 clk = ~clk;

  assign gpr_rs1_data = rf[gpr_rs1_addr];
  assign gpr_rs2_data = rf[gpr_rs2_addr];

  id_stage dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
    .stall(stall), .flush(flush),
    .gpr_rs1_addr(gpr_rs1_addr), .gpr_rs2_addr(gpr_rs2_addr),
    .gpr_rs1_data(gpr_rs1_data), .gpr_rs2_data(gpr_rs2_data),
    .ex_fwd_data(ex_fwd_data),
    .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
    .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .id_illegal(id_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic ins_t mk(kind_e k, int op, int rd, int rs1, int rs2, logic [31:0] imm);
    ins_t d;
    d.kind = k; d.op = op; d.imm = imm; d.raw = 32'd0;
    d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    return d;
  endfunction

  function automatic logic [31:0] enc(ins_t d);
    logic [31:0] im;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  bf3;
    im  = d.imm;
    f3  = (d.kind == K_OP || d.kind == K_OPI) ? 3'(f3_tab[d.op]) : 3'd0;
    f7  = (d.kind == K_OP) ? 7'(f7_tab[d.op]) : 7'd0;
    bf3 = (d.kind == K_BR) ? 3'(bf3_tab[d.op]) : 3'd0;
    case (d.kind)
      K_OP:    return {f7, d.rs2, d.rs1, f3, d.rd, 7'b0110011};
      K_OPI:   return {im[11:0], d.rs1, f3, d.rd, 7'b0010011};
      K_LUI:   return {im[31:12], d.rd, 7'b0110111};
      K_AUIPC: return {im[31:12], d.rd, 7'b0010111};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], d.rd, 7'b1101111};
      K_JALR:  return {im[11:0], d.rs1, 3'b000, d.rd, 7'b1100111};
      K_BR:    return {im[12], im[10:5], d.rs2, d.rs1, bf3, im[4:1], im[11], 7'b1100011};
      K_LW:    return {im[11:0], d.rs1, 3'b010, d.rd, 7'b0000011};
      K_SW:    return {im[11:5], d.rs2, d.rs1, 3'b010, im[4:0], 7'b0100011};
      default: return d.raw;
    endcase
  endfunction

  function automatic logic br_cond(int c, logic [31:0] a, logic [31:0] b);
    case (c)
      0:       return a == b;
      1:       return a != b;
      2:       return $signed(a) <  $signed(b);
      3:       return $signed(a) >= $signed(b);
      4:       return a < b;
      default: return a >= b;
    endcase
  endfunction

  // What ID/EX should hold after accepting instruction d with operand values v1/v2.
  function automatic exp_t model(ins_t d, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2);
    exp_t e;
    e = '0;
    e.pc = pc;
    e.en = 1'b1;
    case (d.kind)
      K_OP:          begin e.alu_op = 4'(d.op); e.in0 = v1; e.in1 = v2;    e.we = (d.rd != 0); end
      K_OPI:         begin e.alu_op = 4'(d.op); e.in0 = v1; e.in1 = d.imm; e.we = (d.rd != 0); end
      K_LUI:         begin e.in1 = d.imm; e.we = (d.rd != 0); end
      K_AUIPC:       begin e.in0 = pc; e.in1 = d.imm; e.we = (d.rd != 0); end
      K_JAL, K_JALR: begin e.in0 = pc; e.in1 = 32'd4; e.we = (d.rd != 0); end
      K_BR:          ;
      K_LW:          begin e.in0 = v1; e.in1 = d.imm; e.mem = 2'd1; e.we = (d.rd != 0); end
      K_SW:          begin e.in0 = v1; e.in1 = d.imm; e.mem = 2'd2; e.wr = v2; end
      default:       e.ill = 1'b1;
    endcase
    e.dst = e.we ? d.rd : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] se12(logic [31:0] r);
    return {{20{r[11]}}, r[11:0]};
  endfunction

  function automatic ins_t make_rand();
    ins_t        d;
    logic [31:0] r;
    int          v;
    r = $urandom;
    d = mk(kind_e'($urandom_range(0, 9)), 0, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), se12(r));
    case (d.kind)
      K_OP: d.op = $urandom_range(0, 9);
      K_OPI: begin
        d.op = $urandom_range(0, 8);
        if (d.op >= 1) d.op = d.op + 1;          // no SUBI
        if (d.op == 5 || d.op == 6) d.imm = 32'(r[4:0]);
        if (d.op == 7) d.imm = 32'h400 + 32'(r[4:0]);
      end
      K_LUI, K_AUIPC: d.imm = {r[31:12], 12'd0};
      K_JAL: d.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BR: begin
        d.op  = $urandom_range(0, 5);
        d.imm = {{19{r[12]}}, r[12:1], 1'b0};
      end
      K_ILL: begin
        v = $urandom_range(0, 3);
        case (v)
          0:       d.raw = 32'hFFFF_FFFF;
          1:       d.raw = {r[31:7], 7'b1110011};                  // SYSTEM
          2:       d.raw = {r[31:15], 3'b000, r[11:7], 7'b0000011}; // LB
          default: d.raw = {7'b0000001, r[24:7], 7'b0110011};      // M-extension
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

  // Drive one cycle of inputs, check the combinational outputs, predict ID/EX.
  task automatic apply(input ins_t d, input logic [31:0] pc, input logic en,
                       input logic st, input logic fl);
    logic [31:0] w, v1, v2, ba;
    logic [4:0]  a1, a2;
    logic        u1, u2, raw, hz, fw1, fw2, jump;
    w = enc(d);
    if_insn = w; if_pc = pc; if_en = en; stall = st; flush = fl;
    ex_fwd_data = fwd_val;
    #2;
    a1   = w[19:15];
    a2   = w[24:20];
    u1   = d.kind inside {K_OP, K_OPI, K_JALR, K_BR, K_LW, K_SW};
    u2   = d.kind inside {K_OP, K_BR, K_SW};
    raw  = cur.en && cur.we && (cur.dst != 0) &&
           ((u1 && a1 == cur.dst) || (u2 && a2 == cur.dst));
    hz   = en && raw && (!FWD || cur.mem == 2'd1);
    fw1  = FWD && cur.en && cur.we && (cur.dst != 0) && (cur.mem != 2'd1) && (a1 == cur.dst);
    fw2  = FWD && cur.en && cur.we && (cur.dst != 0) && (cur.mem != 2'd1) && (a2 == cur.dst);
    v1   = fw1 ? fwd_val : rf[a1];
    v2   = fw2 ? fwd_val : rf[a2];
    jump = (d.kind == K_JAL) || (d.kind == K_JALR) || (d.kind == K_BR && br_cond(d.op, v1, v2));
    check("rs1_addr", 32'(gpr_rs1_addr), 32'(a1));
    check("rs2_addr", 32'(gpr_rs2_addr), 32'(a2));
    check("ld_hazard", 32'(ld_hazard), 32'(hz));
    check("br_taken", 32'(br_taken), 32'(en && !hz && !fl && jump));
    ba = (d.kind == K_JALR) ? ((v1 + d.imm) & ~32'd1) : (pc + d.imm);
    if (d.kind inside {K_JAL, K_JALR, K_BR}) check("br_addr", br_addr, ba);
    if (fl)              nxt = '0;
    else if (st)         nxt = cur;
    else if (hz || !en)  nxt = '0;
    else                 nxt = model(d, pc, v1, v2);
  endtask

  task automatic check_regs();
    check("id_pc", id_pc, cur.pc);
    check("id_en", 32'(id_en), 32'(cur.en));
    check("id_alu_op", 32'(id_alu_op), 32'(cur.alu_op));
    check("id_alu_in_0", id_alu_in_0, cur.in0);
    check("id_alu_in_1", id_alu_in_1, cur.in1);
    check("id_mem_op", 32'(id_mem_op), 32'(cur.mem));
    check("id_mem_wr_data", id_mem_wr_data, cur.wr);
    check("id_dst_addr", 32'(id_dst_addr), 32'(cur.dst));
    check("id_gpr_we", 32'(id_gpr_we), 32'(cur.we));
    check("id_illegal", 32'(id_illegal), 32'(cur.ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur = nxt;
    check_regs();
  endtask

  initial begin
    ins_t        d;
    logic [31:0] r;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    fwd_val = 32'd0;
    reset = 1'b0; if_pc = '0; if_insn = '0; if_en = 1'b0;
    stall = 1'b0; flush = 1'b0; ex_fwd_data = '0;
    cur = '0; nxt = '0;
    #1;
    check_regs();                                   // reset state
    @(negedge clk);
    reset = 1'b1;

    // addi x1,x0,5 at 0x100
    apply(mk(K_OPI, 0, 1, 0, 0, 32'd5), 32'h100, 1'b1, 1'b0, 1'b0);
    tick();
    check("addi_en", 32'(id_en), 32'd1);
    check("addi_in1", id_alu_in_1, 32'd5);
    check("addi_dst", 32'(id_dst_addr), 32'd1);
    check("addi_we", 32'(id_gpr_we), 32'd1);

    // lw x2,0(x1) then add x3,x2,x2: one hazard cycle, one bubble
    apply(mk(K_OPI, 0, 0, 0, 0, 32'd0), 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(mk(K_LW, 0, 2, 1, 0, 32'd0), 32'h104, 1'b1, 1'b0, 1'b0);
    tick();
    apply(mk(K_OP, 0, 3, 2, 2, 32'd0), 32'h108, 1'b1, 1'b0, 1'b0);
    check("lu_hazard", 32'(ld_hazard), 32'd1);
    tick();
    check("lu_bubble", 32'(id_en), 32'd0);
    apply(mk(K_OP, 0, 3, 2, 2, 32'd0), 32'h108, 1'b1, 1'b0, 1'b0);
    check("lu_clear", 32'(ld_hazard), 32'd0);
    tick();
    check("lu_add_dst", 32'(id_dst_addr), 32'd3);

    // beq x0,x0,-8 at 0x200, then the same with flush
    apply(mk(K_BR, 0, 0, 0, 0, 32'hFFFF_FFF8), 32'h200, 1'b1, 1'b0, 1'b0);
    check("beq_taken", 32'(br_taken), 32'd1);
    check("beq_addr", br_addr, 32'h1F8);
    apply(mk(K_BR, 0, 0, 0, 0, 32'hFFFF_FFF8), 32'h200, 1'b1, 1'b0, 1'b1);
    check("beq_flush", 32'(br_taken), 32'd0);
    tick();

    // addi x5 then sub x6,x5,x0 with an EX result of 0x1234
    fwd_val = 32'h1234;
    apply(mk(K_OPI, 0, 5, 0, 0, 32'd7), 32'h300, 1'b1, 1'b0, 1'b0);
    tick();
    apply(mk(K_OP, 1, 6, 5, 0, 32'd0), 32'h304, 1'b1, 1'b0, 1'b0);
    check("fwd_hazard", 32'(ld_hazard), FWD ? 32'd0 : 32'd1);
    tick();
    check("fwd_in0", id_alu_in_0, FWD ? 32'h1234 : 32'd0);

    // three stalled cycles, then reset in the middle of the stall
    apply(mk(K_OPI, 0, 0, 0, 0, 32'd0), 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(mk(K_OPI, 0, 7, 0, 0, 32'h55), 32'h400, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(make_rand(), 32'h404, 1'b1, 1'b1, 1'b0);
      tick();
      check("stall_in1", id_alu_in_1, 32'h55);
      check("stall_pc", id_pc, 32'h400);
    end
    #1;
    reset = 1'b0;
    #1;
    cur = '0;
    nxt = '0;
    check_regs();
    #1;
    reset = 1'b1;
    apply(mk(K_OPI, 0, 8, 0, 0, 32'h66), 32'h500, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_in1", id_alu_in_1, 32'h66);

    // all-ones word is not an instruction
    d = mk(K_ILL, 0, 0, 0, 0, 32'd0);
    d.raw = 32'hFFFF_FFFF;
    apply(d, 32'h600, 1'b1, 1'b0, 1'b0);
    tick();
    check("ill_flag", 32'(id_illegal), 32'd1);
    check("ill_we", 32'(id_gpr_we), 32'd0);
    check("ill_mem", 32'(id_mem_op), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      fwd_val = $urandom;
      apply(make_rand(), {r[31:2], 2'b00}, ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 8));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs if_pc[31:0], if_insn[31:0], if_en: IF/ID register contents and valid mark.
REQ-004 SHALL have inputs stall, flush (1 each) from pipeline control.
REQ-005 SHALL have outputs gpr_rs1_addr[4:0], gpr_rs2_addr[4:0] = if_insn[19:15], if_insn[24:20]; inputs gpr_rs1_data[31:0], gpr_rs2_data[31:0] from the register file, same cycle.
REQ-006 SHALL have inputs ex_fwd_data[31:0]: EX result of the instruction held in ID/EX.
REQ-007 SHALL have outputs br_taken (1) and br_addr[31:0] to IF, plus ld_hazard (1) to pipeline control.
REQ-008 SHALL have registered outputs id_pc[31:0], id_en, id_alu_op[3:0], id_alu_in_0[31:0], id_alu_in_1[31:0], id_mem_op[1:0], id_mem_wr_data[31:0], id_dst_addr[4:0], id_gpr_we, id_illegal.

Function
REQ-009 SHALL decode RV32I: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU), LOAD (LW only), STORE (SW only).
REQ-010 SHALL encode id_alu_op: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9; id_mem_op: NOP 0, LW 1, SW 2.
REQ-011 SHALL sign-extend I/S/B/J immediates to 32 bits; U immediate = insn[31:12]<<12; all address sums modulo 2^32.
REQ-012 SHALL for any other encoding set id_illegal=1, id_gpr_we=0, id_mem_op=NOP, id_en=if_en.
REQ-013 SHALL force id_gpr_we=0 when rd=0; JAL/JALR SHALL produce alu_in_0=pc, alu_in_1=4, op ADD.
REQ-014 SHALL compute br_addr: JAL/BRANCH pc+imm; JALR (rs1+imm) with bit0 cleared.
REQ-015 SHALL assert br_taken combinationally only when if_en & ~ld_hazard & ~flush and (JAL, JALR, or branch condition true on resolved operands).
REQ-016 SHALL assert ld_hazard when if_en, id_en, id_mem_op=LW, id_dst_addr!=0, and id_dst_addr equals a source register the instruction actually reads.
REQ-017 SHALL update ID/EX register per cycle with priority: flush -> bubble; else stall -> hold all; else ld_hazard -> bubble; else load decoded values.
REQ-018 Bubble SHALL mean id_en=0, id_gpr_we=0, id_mem_op=NOP, id_illegal=0, data fields zero.
REQ-019 SHALL latch id_en=0 whenever if_en=0 (non-stall cycles).
REQ-020 Simultaneous flush and ld_hazard SHALL produce a bubble and ld_hazard SHALL still be reported.

Reset
REQ-021 SHALL on reset low asynchronously clear every ID/EX output to 0 (id_en=0, id_mem_op=NOP); combinational outputs follow inputs.
REQ-022 SHALL on reset release mid-stream accept the next if_en instruction on the first edge after release.

Configuration
REQ-023 SHALL use macro ID_FWD_EN; defined: rs operand equal to id_dst_addr (non-zero, id_gpr_we, id_en, not LW) takes ex_fwd_data in place of gpr data, for ALU inputs, store data and branch compare.
REQ-024 Without ID_FWD_EN: no forwarding; ld_hazard SHALL extend to any RAW match against id_dst_addr with id_gpr_we & id_en, any mem_op.

Verification
REQ-025 addi x1,x0,5 at pc 0x100 -> next cycle id_en=1, id_alu_op=0, alu_in_0=0, alu_in_1=5, id_dst_addr=1, id_gpr_we=1.
REQ-026 lw x2,0(x1) then add x3,x2,x2 -> ld_hazard=1 one cycle, one bubble latched, add latched next cycle.
REQ-027 beq x0,x0,-8 at pc 0x200 -> br_taken=1, br_addr=0x1F8; with flush=1 same cycle br_taken=0.
REQ-028 With ID_FWD_EN: addi x5 then sub x6,x5,x0, ex_fwd_data=0x1234 -> alu_in_0=0x1234, ld_hazard=0; without macro ld_hazard=1.
REQ-029 stall=1 held 3 cycles -> outputs frozen; reset low mid-stall -> all outputs 0 immediately.
REQ-030 insn 0xFFFFFFFF, if_en=1 -> id_illegal=1, id_gpr_we=0, id_mem_op=0.
